// File: rtl/reverb_pkg.sv
`default_nettype none
// ============================================================================
// reverb_pkg : shared constants and FSM encoding for the reverb tap scheduler
// Rev 1.0
// ============================================================================
package reverb_pkg;

    localparam int NUM_TAPS   = 4;
    localparam int TAP_BASE_W = 12;
    localparam int TAP_IDX_W  = $clog2(NUM_TAPS);

    // Comb-line base delays, entry 0 in the least significant slot
    localparam logic [NUM_TAPS-1:0][TAP_BASE_W-1:0] TAP_BASE =
        {12'd1356, 12'd1277, 12'd1188, 12'd1116};

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        DONE    = 3'd4
    } state_e;

endpackage
`default_nettype wire

// File: rtl/reverb_tap_addr.sv
`default_nettype none
// ============================================================================
// reverb_tap_addr : scales one tap's base delay by room size, clamps, and
//                   turns it into a circular-buffer read address
// Rev 1.0
// ============================================================================
module reverb_tap_addr
    import reverb_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int PARAM_W = 8
) (
    input  logic [TAP_IDX_W-1:0] tap_k,
    input  logic [PARAM_W-1:0]   size,
    input  logic [ADDR_W-1:0]    wr_ptr,
    output logic [ADDR_W-1:0]    addr
);

    localparam int PROD_W = ADDR_W + PARAM_W + 1;

    logic [PROD_W-1:0] base_ext;
    logic [PROD_W-1:0] scale_ext;
    logic [PROD_W-1:0] prod;
    logic [ADDR_W-1:0] tap_delay;

    always_comb begin
        base_ext  = PROD_W'(TAP_BASE[tap_k]);
        scale_ext = PROD_W'(size) + PROD_W'(1);
        prod      = base_ext * scale_ext;
        // (size+1) <= 2^PARAM_W, so the shifted product always fits ADDR_W bits
        tap_delay = ADDR_W'(prod >> PARAM_W);
        if (tap_delay == '0) begin
            tap_delay = ADDR_W'(1);
        end
        addr = wr_ptr - tap_delay;
    end

endmodule
`default_nettype wire

// File: rtl/reverb_tap_scheduler.sv
`default_nettype none
// ============================================================================
// reverb_tap_scheduler : per-sample read of NUM_TAPS delayed taps followed by
//                        one write into the shared single-port delay RAM
// Rev 1.0
// ============================================================================
module reverb_tap_scheduler
    import reverb_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int PARAM_W = 8,
    parameter int ADDR_W  = 12
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 sample_en,
    input  logic [DATA_W-1:0]    wr_data,
    input  logic [PARAM_W-1:0]   fx_size,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]    mem_wdata,
    input  logic                 mem_gnt,
    input  logic                 mem_rvalid,
    input  logic [DATA_W-1:0]    mem_rdata,
    output logic                 tap_valid,
    output logic [TAP_IDX_W-1:0] tap_idx,
    output logic [DATA_W-1:0]    tap_data,
    output logic                 frame_done,
    output logic                 busy,
    output logic                 overrun
);

    localparam logic [TAP_IDX_W-1:0] LAST_TAP = TAP_IDX_W'(NUM_TAPS - 1);

    state_e               state_q, state_d;
    logic [TAP_IDX_W-1:0] k_q, k_d;
    logic [PARAM_W-1:0]   size_q, size_d;
    logic [DATA_W-1:0]    sample_q, sample_d;
    logic [ADDR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic                 mem_req_q, mem_req_d;
    logic                 mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]    mem_wdata_q, mem_wdata_d;
    logic                 tap_valid_q, tap_valid_d;
    logic [TAP_IDX_W-1:0] tap_idx_q, tap_idx_d;
    logic [DATA_W-1:0]    tap_data_q, tap_data_d;
    logic                 frame_done_q, frame_done_d;
    logic                 busy_q, busy_d;
    logic                 overrun_q, overrun_d;
    logic [ADDR_W-1:0]    tap_addr;
    logic                 mem_grant;

    assign mem_grant = mem_req_q & mem_gnt;

    // Fed from next-state values so the request address is ready the cycle RD_REQ begins
    reverb_tap_addr #(
        .ADDR_W  (ADDR_W),
        .PARAM_W (PARAM_W)
    ) u_tap_addr (
        .tap_k  (k_d),
        .size   (size_d),
        .wr_ptr (wr_ptr_q),
        .addr   (tap_addr)
    );

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        size_d      = size_q;
        sample_d    = sample_q;
        wr_ptr_d    = wr_ptr_q;
        tap_valid_d = 1'b0;
        tap_idx_d   = tap_idx_q;
        tap_data_d  = tap_data_q;
        overrun_d   = overrun_q | (sample_en & (state_q != IDLE));

        case (state_q)
            IDLE: begin
                if (sample_en) begin
                    size_d   = fx_size;
                    sample_d = wr_data;
                    k_d      = '0;
                    state_d  = RD_REQ;
                end
            end
            RD_REQ: begin
                if (mem_grant) begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (mem_rvalid) begin
                    tap_valid_d = 1'b1;
                    tap_idx_d   = k_q;
                    tap_data_d  = mem_rdata;
                    if (k_q == LAST_TAP) begin
                        state_d = WR_REQ;
                    end else begin
                        k_d     = k_q + 1'b1;
                        state_d = RD_REQ;
                    end
                end
            end
            WR_REQ: begin
                if (mem_grant) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_d       = (state_d != IDLE);
        frame_done_d = (state_d == DONE);
        mem_req_d    = (state_d == RD_REQ) || (state_d == WR_REQ);
        mem_we_d     = (state_d == WR_REQ);
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if (state_d == RD_REQ) begin
            mem_addr_d = tap_addr;
        end else if (state_d == WR_REQ) begin
            mem_addr_d  = wr_ptr_q;
            mem_wdata_d = sample_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            k_q          <= '0;
            size_q       <= '0;
            sample_q     <= '0;
            wr_ptr_q     <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            tap_valid_q  <= 1'b0;
            tap_idx_q    <= '0;
            tap_data_q   <= '0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            size_q       <= size_d;
            sample_q     <= sample_d;
            wr_ptr_q     <= wr_ptr_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            tap_valid_q  <= tap_valid_d;
            tap_idx_q    <= tap_idx_d;
            tap_data_q   <= tap_data_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign tap_valid  = tap_valid_q;
    assign tap_idx    = tap_idx_q;
    assign tap_data   = tap_data_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;
    assign overrun    = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_reverb_tap_scheduler.sv
`default_nettype none
// ============================================================================
// tb_reverb_tap_scheduler : directed and randomized frames checked against a
//                           behavioural delay-line model and RAM responder
// Rev 1.0
// ============================================================================
module tb_reverb_tap_scheduler;

    localparam int NT    = 4;
    localparam int DEPTH = 4096;
    localparam int BASE [NT] = '{1116, 1188, 1277, 1356};

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sample_en = 1'b0;
    logic [15:0] wr_data = '0;
    logic [7:0]  fx_size = '0;
    logic        mem_req, mem_we;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic        tap_valid;
    logic [1:0]  tap_idx;
    logic [15:0] tap_data;
    logic        frame_done, busy, overrun;

    reverb_tap_scheduler #(.DATA_W(16), .PARAM_W(8), .ADDR_W(12)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sample_en  (sample_en),
        .wr_data    (wr_data),
        .fx_size    (fx_size),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .tap_valid  (tap_valid),
        .tap_idx    (tap_idx),
        .tap_data   (tap_data),
        .frame_done (frame_done),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [15:0] ram     [DEPTH];
    logic [15:0] ref_ram [DEPTH];

    // behavioural model state
    int  m_wr_ptr, m_rd_k, m_sample;
    int  m_addr [NT];
    bit  m_busy, m_overrun;
    int  accept_cyc, frame_len, wr_log, fd_seen;
    int  tv_cyc [NT];
    int  rd_log [NT];

    // previous-cycle observations for handshake and latency rules
    bit  prev_req, prev_we, prev_granted, prev_wr_grant, prev_rv_legit;
    int  prev_addr, prev_wdata;
    int  exp_tap_idx, exp_tap_data;

    // RAM responder
    bit          pend_active;
    int          pend_cnt, pend_idx, pend_exp;
    logic [15:0] pend_data;

    // stimulus knobs
    bit req_sample;
    int req_fx, req_data;
    int gnt_pct = 100, lat_lo = 1, lat_hi = 1, stray_pct = 0;
    int stall_tap = -1, stall_left = 0;

    task automatic check_val(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic int ref_addr(input int k, input int size, input int wp);
        int d;
        d = (BASE[k] * (size + 1)) / 256;
        if (d < 1) d = 1;
        return ((wp - d) % DEPTH + DEPTH) % DEPTH;
    endfunction

    task automatic model_reset();
        m_wr_ptr = 0; m_rd_k = 0; m_busy = 0; m_overrun = 0;
        prev_req = 0; prev_we = 0; prev_granted = 0; prev_wr_grant = 0; prev_rv_legit = 0;
        pend_active = 0; pend_cnt = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        cyc++;
        reset_n = 1'b0; sample_en = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        @(negedge clk);
        cyc++;
        check_val("rst_mem_req",    int'(mem_req), 0);
        check_val("rst_mem_we",     int'(mem_we), 0);
        check_val("rst_mem_addr",   int'(mem_addr), 0);
        check_val("rst_busy",       int'(busy), 0);
        check_val("rst_frame_done", int'(frame_done), 0);
        check_val("rst_tap_valid",  int'(tap_valid), 0);
        check_val("rst_overrun",    int'(overrun), 0);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic step();
        bit next_busy, gnt, rv, legit, granted;
        logic [15:0] rd;
        @(negedge clk);
        cyc++;

        check_val("tap_valid", int'(tap_valid), int'(prev_rv_legit));
        if (prev_rv_legit) begin
            check_val("tap_idx",  int'(tap_idx), exp_tap_idx);
            check_val("tap_data", int'(tap_data), exp_tap_data);
            tv_cyc[exp_tap_idx] = cyc - accept_cyc;
        end
        check_val("frame_done", int'(frame_done), int'(prev_wr_grant));
        check_val("busy", int'(busy), int'(m_busy));
        check_val("overrun", int'(overrun), int'(m_overrun));
        if (prev_req && !prev_granted) begin
            check_val("req_hold",  int'(mem_req), 1);
            check_val("addr_hold", int'(mem_addr), prev_addr);
            check_val("we_hold",   int'(mem_we), int'(prev_we));
            if (prev_we) check_val("wdata_hold", int'(mem_wdata), prev_wdata);
        end
        if (prev_granted) check_val("req_drop", int'(mem_req), 0);
        if (frame_done) fd_seen++;

        next_busy = m_busy;
        if (prev_wr_grant) begin
            frame_len = cyc - accept_cyc;
            m_wr_ptr  = (m_wr_ptr + 1) % DEPTH;
            next_busy = 0;
        end

        sample_en = req_sample;
        wr_data   = 16'(req_data);
        fx_size   = 8'(req_fx);
        if (req_sample) begin
            if (m_busy) begin
                m_overrun = 1;
            end else begin
                m_sample   = req_data;
                m_rd_k     = 0;
                accept_cyc = cyc;
                for (int k = 0; k < NT; k++) m_addr[k] = ref_addr(k, req_fx, m_wr_ptr);
                next_busy  = 1;
            end
        end
        req_sample = 0;

        rv = 0; legit = 0; rd = 16'($urandom);
        if (pend_active) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                rv = 1; legit = 1; rd = pend_data; pend_active = 0;
                exp_tap_idx = pend_idx; exp_tap_data = pend_exp;
            end
        end else if (stray_pct > 0 && $urandom_range(1, 100) <= stray_pct) begin
            rv = 1;
        end
        mem_rvalid = rv;
        mem_rdata  = rd;

        gnt = ($urandom_range(1, 100) <= gnt_pct);
        if (mem_req && !mem_we && m_rd_k == stall_tap && stall_left > 0) begin
            gnt = 0;
            stall_left--;
        end
        mem_gnt = gnt;
        granted = mem_req && gnt;

        if (granted && !mem_we) begin
            check_val("rd_expected", int'(m_busy && !pend_active && m_rd_k < NT), 1);
            if (m_rd_k < NT) begin
                check_val("rd_addr", int'(mem_addr), m_addr[m_rd_k]);
                rd_log[m_rd_k] = int'(mem_addr);
                pend_active = 1;
                pend_cnt    = $urandom_range(lat_lo, lat_hi);
                pend_data   = ram[mem_addr];
                pend_idx    = m_rd_k;
                pend_exp    = int'(ref_ram[m_addr[m_rd_k]]);
                m_rd_k++;
            end
        end
        if (granted && mem_we) begin
            check_val("wr_order", m_rd_k, NT);
            check_val("wr_addr",  int'(mem_addr), m_wr_ptr);
            check_val("wr_data",  int'(mem_wdata), m_sample);
            ram[mem_addr]      = mem_wdata;
            ref_ram[m_wr_ptr]  = 16'(m_sample);
            wr_log             = int'(mem_addr);
        end

        prev_req      = mem_req;
        prev_we       = mem_we;
        prev_addr     = int'(mem_addr);
        prev_wdata    = int'(mem_wdata);
        prev_granted  = granted;
        prev_wr_grant = granted && mem_we;
        prev_rv_legit = legit;
        m_busy        = next_busy;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400 && m_busy; i++) step();
        check_val("idle_reached", int'(m_busy), 0);
    endtask

    task automatic run_frame(input int fx, input int data);
        wait_idle();
        for (int k = 0; k < NT; k++) begin rd_log[k] = -1; tv_cyc[k] = -1; end
        wr_log = -1;
        req_sample = 1; req_fx = fx; req_data = data;
        step();
        for (int i = 0; i < 400 && m_busy; i++) step();
        check_val("frame_end", int'(m_busy), 0);
    endtask

    initial begin
        int basic_addr [NT];
        int fd_before;
        basic_addr = '{2980, 2908, 2819, 2740};
        for (int i = 0; i < DEPTH; i++) begin
            ram[i]     = 16'($urandom);
            ref_ram[i] = ram[i];
        end
        req_sample = 0; req_fx = 0; req_data = 0; fd_seen = 0;
        model_reset();
        do_reset();

        // basic frame, reference timing
        run_frame(255, 16'h1234);
        for (int k = 0; k < NT; k++) begin
            check_val("basic_rd_addr", rd_log[k], basic_addr[k]);
            check_val("basic_tap_cycle", tv_cyc[k], 3 + 2 * k);
        end
        check_val("basic_wr_addr", wr_log, 0);
        check_val("basic_frame_len", frame_len, 2 * NT + 2);

        // size scaling
        run_frame(127, $urandom_range(0, 65535));
        check_val("size127_tap0", rd_log[0], 3539);
        run_frame(0, $urandom_range(0, 65535));
        check_val("size0_tap0", rd_log[0], 4094);

        // grant stall on tap 1
        stall_tap = 1; stall_left = 5;
        run_frame(255, $urandom_range(0, 65535));
        check_val("stall_tap0_cycle", tv_cyc[0], 3);
        check_val("stall_tap1_cycle", tv_cyc[1], 10);
        check_val("stall_frame_len", frame_len, 2 * NT + 2 + 5);
        stall_tap = -1;

        // overrun: second sample at cycle 4, then stray rvalid while idle
        wait_idle();
        fd_before = fd_seen;
        req_sample = 1; req_fx = 200; req_data = 16'hBEEF;
        step();
        for (int i = 0; i < 3; i++) step();
        req_sample = 1; req_fx = 10; req_data = 16'h0BAD;
        step();
        wait_idle();
        step();
        check_val("overrun_one_frame", fd_seen - fd_before, 1);
        check_val("overrun_sticky", int'(overrun), 1);
        stray_pct = 100;
        for (int i = 0; i < 6; i++) step();
        stray_pct = 0;
        run_frame(255, $urandom_range(0, 65535));
        check_val("post_overrun_wr_addr", wr_log, 5);

        // reset in RD_WAIT of tap 2
        lat_lo = 3; lat_hi = 3;
        wait_idle();
        fd_before = fd_seen;
        req_sample = 1; req_fx = 255; req_data = 16'h5A5A;
        step();
        for (int i = 0; i < 100 && !(m_rd_k == 3 && pend_active); i++) step();
        check_val("reached_tap2_wait", int'(m_rd_k == 3 && pend_active), 1);
        do_reset();
        step();
        check_val("rst_no_frame_done", fd_seen - fd_before, 0);
        lat_lo = 1; lat_hi = 1;
        run_frame(255, $urandom_range(0, 65535));
        check_val("after_rst_tap0", rd_log[0], 2980);
        check_val("after_rst_wr_addr", wr_log, 0);

        // run up to the pointer wrap
        for (int i = 0; i < 5000 && m_wr_ptr != DEPTH - 1; i++)
            run_frame($urandom_range(0, 255), $urandom_range(0, 65535));
        run_frame(255, $urandom_range(0, 65535));
        check_val("wrap_wr_addr", wr_log, DEPTH - 1);
        run_frame(255, $urandom_range(0, 65535));
        check_val("wrap_tap0", rd_log[0], 2980);
        check_val("wrap_wr_addr0", wr_log, 0);

        // randomized traffic: stalls, variable latency, overruns, stray rvalid
        gnt_pct = 70; lat_lo = 1; lat_hi = 3; stray_pct = 10;
        for (int i = 0; i < 4000; i++) begin
            req_sample = ($urandom_range(0, 11) == 0);
            req_fx     = $urandom_range(0, 255);
            req_data   = $urandom_range(0, 65535);
            step();
        end
        stray_pct = 0; gnt_pct = 100;
        wait_idle();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
